// File: rtl/mult_div_iter_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The master drives the operation; the slave returns HI/LO, MDOut and status pulses.
interface mult_div_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [3:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Start;
    logic             Flush;
    logic [WIDTH-1:0] HIout;
    logic [WIDTH-1:0] LOout;
    logic [WIDTH-1:0] MDOut;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output MDOp, A, B, Start, Flush,
        input  HIout, LOout, MDOut, Busy, Done, DivZero
    );

    modport slave (
        input  MDOp, A, B, Start, Flush,
        output HIout, LOout, MDOut, Busy, Done, DivZero
    );
endinterface

// File: rtl/mult_div_iter.sv
// HI/LO multiply/divide unit: fixed-latency multiply with MADD/MSUB accumulate and
// restoring radix-2 division (one quotient bit per cycle plus a sign-fix cycle).
module mult_div_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_iter_if.slave bus
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [1:0]       acc_q, acc_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    // Issue-side operand conditioning
    logic             mul_signed;
    logic             div_signed;
    logic [W2-1:0]    a_ext, b_ext;
    logic [W2-1:0]    product;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        mul_signed = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_MADD) || (bus.MDOp == OP_MSUB);
        div_signed = (bus.MDOp == OP_DIV);
        a_ext = mul_signed ? {{WIDTH{bus.A[WIDTH-1]}}, bus.A} : {{WIDTH{1'b0}}, bus.A};
        b_ext = mul_signed ? {{WIDTH{bus.B[WIDTH-1]}}, bus.B} : {{WIDTH{1'b0}}, bus.B};
        // Low 2W bits of the sign/zero-extended product are exact for both signednesses
        product = a_ext * b_ext;
        a_abs = (div_signed && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
        b_abs = (div_signed && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;
    end

    // Completion value of a multiply/accumulate
    logic [W2-1:0] acc_val;
    logic [W2-1:0] mul_result;

    always_comb begin
        acc_val = {hi_q, lo_q};
        case (acc_q)
            ACC_ADD: mul_result = acc_val + prod_q;
            ACC_SUB: mul_result = acc_val - prod_q;
            default: mul_result = prod_q;
        endcase
    end

    // One restoring-division step: bring in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;

    always_comb begin
        shifted   = {rem_q, quot_q[WIDTH-1]};
        diff      = shifted - {1'b0, divisor_q};
        take      = ~diff[WIDTH];
        rem_step  = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_step = {quot_q[WIDTH-2:0], take};
    end

    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;

    always_comb begin
        quot_fixed = q_neg_q ? (~quot_q + 1'b1) : quot_q;
        rem_fixed  = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        if (bus.Flush) begin
            // Abort wins over both issue and completion; HI/LO are left untouched
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start) begin
                        case (bus.MDOp)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                prod_d  = product;
                                acc_d   = ((bus.MDOp == OP_MADD) || (bus.MDOp == OP_MADDU)) ?
                                          ACC_ADD :
                                          ((bus.MDOp == OP_MSUB) || (bus.MDOp == OP_MSUBU)) ?
                                          ACC_SUB : ACC_NONE;
                                state_d = ST_MUL;
                                cnt_d   = CW'(MUL_LAT - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.B == '0) begin
                                    divzero_d = 1'b1;
                                end else begin
                                    divisor_d = b_abs;
                                    quot_d    = a_abs;
                                    rem_d     = '0;
                                    q_neg_d   = div_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                                    r_neg_d   = div_signed && bus.A[WIDTH-1];
                                    state_d   = ST_DIV;
                                    cnt_d     = CW'(WIDTH - 1);
                                end
                            end
                            OP_MTHI: hi_d = bus.A;
                            OP_MTLO: lo_d = bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = mul_result;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_DIV: begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_FIX: begin
                    lo_d    = quot_fixed;
                    hi_d    = rem_fixed;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            prod_q    <= '0;
            acc_q     <= ACC_NONE;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        case (bus.MDOp)
            OP_MFHI: bus.MDOut = hi_q;
            OP_MFLO: bus.MDOut = lo_q;
            default: bus.MDOut = '0;
        endcase
    end

    assign bus.HIout   = hi_q;
    assign bus.LOout   = lo_q;
    assign bus.Busy    = (state_q != ST_IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;

endmodule

// File: tb/tb_mult_div_iter.sv
// Randomised scoreboard bench for mult_div_iter: expected HI/LO results are queued at issue
// and matched by a monitor against every Done/DivZero pulse.
module tb_mult_div_iter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MUL_LAT = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mult_div_iter_if #(.WIDTH(WIDTH)) bus ();

    mult_div_iter #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: plain arithmetic on the architectural HI/LO pair
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        logic [63:0] prod, acc;
        logic [31:0] q, r;
        int          sa, sb;
        exp_t        e;
        lat  = 0;
        prod = '0;
        acc  = {m_hi, m_lo};
        if (op inside {4'd0, 4'd8, 4'd10})
            prod = 64'(longint'($signed(a)) * longint'($signed(b)));
        else if (op inside {4'd1, 4'd9, 4'd11})
            prod = {32'd0, a} * {32'd0, b};
        if (op inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11}) begin
            if (op inside {4'd8, 4'd9}) acc = acc + prod;
            else if (op inside {4'd10, 4'd11}) acc = acc - prod;
            else acc = prod;
            {m_hi, m_lo} = acc;
            lat = MUL_LAT;
            e = '{dz: 1'b0, hi: m_hi, lo: m_lo};
            sb_q.push_back(e);
        end else if (op inside {4'd2, 4'd3}) begin
            if (b == 32'd0) begin
                e = '{dz: 1'b1, hi: m_hi, lo: m_lo};
                sb_q.push_back(e);
            end else begin
                if (op == 4'd3) begin
                    q = a / b;
                    r = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = a;
                    r = 32'd0;
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = 32'(sa / sb);
                    r  = 32'(sa % sb);
                end
                m_hi = r;
                m_lo = q;
                lat  = WIDTH + 1;
                e = '{dz: 1'b0, hi: m_hi, lo: m_lo};
                sb_q.push_back(e);
            end
        end else if (op == 4'd6) begin
            m_hi = a;
        end else if (op == 4'd7) begin
            m_lo = a;
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, n;
        @(negedge clk);
        model(op, a, b, lat);
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.MDOp  = 4'd12;
        n = 0;
        while (bus.Busy && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check($sformatf("busy_cycles op%0d", op), 64'(n), 64'(lat));
        check("hi_after_op", 64'(bus.HIout), 64'(m_hi));
        check("lo_after_op", 64'(bus.LOout), 64'(m_lo));
    endtask

    task automatic check_mdout();
        bus.MDOp = 4'd4;
        #1 check("mdout_mfhi", 64'(bus.MDOut), 64'(m_hi));
        bus.MDOp = 4'd5;
        #1 check("mdout_mflo", 64'(bus.MDOut), 64'(m_lo));
        bus.MDOp = 4'd13;
        #1 check("mdout_noop", 64'(bus.MDOut), 64'd0);
        bus.MDOp = 4'd12;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners[5];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            1:       return 32'($urandom_range(0, 255));
            2:       return corners[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every result pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.Done || bus.DivZero)) begin
                check("pulse_while_busy", 64'(bus.Busy), 64'd0);
                check("done_and_divzero", 64'(bus.Done & bus.DivZero), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse_sb_size", 64'd0, 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_kind_divzero", 64'(bus.DivZero), 64'(e.dz));
                    check("sb_hi", 64'(bus.HIout), 64'(e.hi));
                    check("sb_lo", 64'(bus.LOout), 64'(e.lo));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops[10];
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          n;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        bus.MDOp  = 4'd12;
        bus.A     = '0;
        bus.B     = '0;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_hi", 64'(bus.HIout), 64'd0);
        check("rst_lo", 64'(bus.LOout), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_divzero", 64'(bus.DivZero), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_vec", 64'(bus.HIout), 64'hFFFF_FFFF);
        check("mult_lo_vec", 64'(bus.LOout), 64'hFFFF_FFFA);
        check_mdout();

        do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_vec", 64'(bus.LOout), 64'hFFFF_FFFD);
        check("div_hi_vec", 64'(bus.HIout), 64'hFFFF_FFFF);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("divu_lo_vec", 64'(bus.LOout), 64'h7FFF_FFFC);
        check("divu_hi_vec", 64'(bus.HIout), 64'h0000_0001);

        do_op(4'd7, 32'hFFFF_FFFF, 32'd0);
        do_op(4'd6, 32'd0, 32'd0);
        do_op(4'd9, 32'd1, 32'd1);
        check("maddu_hi_vec", 64'(bus.HIout), 64'h1);
        check("maddu_lo_vec", 64'(bus.LOout), 64'h0);
        do_op(4'd10, 32'd1, 32'd1);
        check("msub_hi_vec", 64'(bus.HIout), 64'h0);
        check("msub_lo_vec", 64'(bus.LOout), 64'hFFFF_FFFF);

        do_op(4'd6, 32'h1234, 32'd0);
        do_op(4'd7, 32'h1234, 32'd0);
        do_op(4'd2, 32'd77, 32'd0);
        check("divzero_hi_vec", 64'(bus.HIout), 64'h1234);
        check("divzero_lo_vec", 64'(bus.LOout), 64'h1234);

        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("minneg1_lo_vec", 64'(bus.LOout), 64'h8000_0000);
        check("minneg1_hi_vec", 64'(bus.HIout), 64'h0);
        check_mdout();

        // Flush at busy cycle 10, with an ignored Start at busy cycle 3
        @(negedge clk);
        bus.MDOp  = 4'd2;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        n = 0;
        while (bus.Busy && n < 200) begin
            n++;
            bus.Start = (n == 3);
            if (n == 3) begin
                bus.MDOp = 4'd0;
                bus.A    = 32'd5;
                bus.B    = 32'd5;
            end
            bus.Flush = (n == 10);
            @(posedge clk);
            #1;
        end
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.MDOp  = 4'd12;
        check("flush_busy_cycles", 64'(n), 64'd10);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hi_kept", 64'(bus.HIout), 64'(m_hi));
        check("flush_lo_kept", 64'(bus.LOout), 64'(m_lo));

        // Flush together with Start in idle drops the Start
        @(negedge clk);
        bus.MDOp  = 4'd6;
        bus.A     = 32'hCAFE_F00D;
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.MDOp  = 4'd12;
        check("flush_start_busy", 64'(bus.Busy), 64'd0);
        check("flush_start_hi", 64'(bus.HIout), 64'(m_hi));

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            ra = rand_operand();
            rb = rand_operand();
            if (op inside {4'd2, 4'd3} && $urandom_range(0, 7) == 0) rb = 32'd0;
            do_op(op, ra, rb);
            if (i % 8 == 0) check_mdout();
        end

        // Asynchronous reset between edges of an in-flight MULT
        do_op(4'd6, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        bus.MDOp  = 4'd0;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        bus.MDOp = 4'd12;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_hi", 64'(bus.HIout), 64'd0);
        check("async_rst_lo", 64'(bus.LOout), 64'd0);
        check("async_rst_busy", 64'(bus.Busy), 64'd0);
        check("async_rst_done", 64'(bus.Done), 64'd0);
        bus.MDOp = 4'd4;
        #1 check("async_rst_mfhi", 64'(bus.MDOut), 64'd0);
        bus.MDOp = 4'd12;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;

        do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1 check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
